// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_t;

  localparam int unsigned DEF_MAX_DM_BURST = 32'd4;
  localparam int unsigned DEF_TIMEOUT_CYC  = 32'd255;
  localparam int unsigned BURST_W          = 32'd4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF requester, DM requester and memory-side signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32'd30
) ();
  logic              IF_Read;
  logic [ADDR_W-1:0] IF_Address;
  logic              IF_Ready;
  logic [31:0]       IF_Data;
  logic              DM_Read;
  logic [3:0]        DM_Write;
  logic [ADDR_W-1:0] DM_Address;
  logic [31:0]       DM_WriteData;
  logic              DM_Ready;
  logic [31:0]       DM_Data;
  logic              Mem_Read;
  logic [3:0]        Mem_Write;
  logic [ADDR_W-1:0] Mem_Address;
  logic [31:0]       Mem_WriteData;
  logic [31:0]       Mem_ReadData;
  logic              Mem_Ack;
  logic              Arb_Error;

  modport slave (
    input  IF_Read, IF_Address, DM_Read, DM_Write, DM_Address, DM_WriteData,
    input  Mem_ReadData, Mem_Ack,
    output IF_Ready, IF_Data, DM_Ready, DM_Data,
    output Mem_Read, Mem_Write, Mem_Address, Mem_WriteData, Arb_Error
  );

  modport master (
    output IF_Read, IF_Address, DM_Read, DM_Write, DM_Address, DM_WriteData,
    output Mem_ReadData, Mem_Ack,
    input  IF_Ready, IF_Data, DM_Ready, DM_Data,
    input  Mem_Read, Mem_Write, Mem_Address, Mem_WriteData, Arb_Error
  );
endinterface

// File: rtl/mem_port_arbiter_grant.sv
// Combinational grant decision: DM has priority until it has won MAX_DM_BURST
// grants in a row while IF was waiting, then IF gets one turn.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_BURST = DEF_MAX_DM_BURST
) (
  input  logic               if_req_i,
  input  logic               dm_req_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic               grant_o,
  output arb_port_t          port_o,
  output logic [BURST_W-1:0] burst_o
);

  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_DM_BURST);

  // Priority and starvation decision.
  always_comb begin
    grant_o = 1'b0;
    port_o  = PORT_IF;
    burst_o = burst_i;
    if (dm_req_i && (!if_req_i || (burst_i < MAX_B))) begin
      grant_o = 1'b1;
      port_o  = PORT_DM;
      burst_o = if_req_i ? (burst_i + 4'd1) : 4'd0;
    end else if (if_req_i) begin
      grant_o = 1'b1;
      port_o  = PORT_IF;
      burst_o = 4'd0;
    end else begin
      burst_o = burst_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory.
// Optional bus timeout with sticky Arb_Error: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32'd30,
  parameter int unsigned MAX_DM_BURST = DEF_MAX_DM_BURST
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC
`endif
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  arb_port_t         port_q, port_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_q, rd_d;
  logic [3:0]        wr_q, wr_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       dm_data_q, dm_data_d;

  logic               grant_s;
  arb_port_t          grant_port_s;
  logic [BURST_W-1:0] burst_nxt_s;
  logic               dm_req_s;

  assign dm_req_s = bus.DM_Read | (bus.DM_Write != 4'b0000);

  mem_arb_grant #(.MAX_DM_BURST(MAX_DM_BURST)) u_grant (
    .if_req_i (bus.IF_Read),
    .dm_req_i (dm_req_s),
    .burst_i  (burst_q),
    .grant_o  (grant_s),
    .port_o   (grant_port_s),
    .burst_o  (burst_nxt_s)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 32'd1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  // Next-state and capture logic.
  always_comb begin
    state_d   = state_q;
    port_d    = port_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    if_data_d = if_data_q;
    dm_data_d = dm_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    tmo_d     = 8'd0;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = BUSY;
          port_d  = grant_port_s;
          burst_d = burst_nxt_s;
          if (grant_port_s == PORT_DM) begin
            addr_d  = bus.DM_Address;
            wdata_d = bus.DM_WriteData;
            wr_d    = bus.DM_Write;
            // A combined read+write request is served as a write.
            rd_d    = bus.DM_Read & (bus.DM_Write == 4'b0000);
          end else begin
            addr_d  = bus.IF_Address;
            wdata_d = 32'h0000_0000;
            wr_d    = 4'b0000;
            rd_d    = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
        if (bus.Mem_Ack) begin
          state_d = DONE;
          if (port_q == PORT_IF) begin
            if_data_d = bus.Mem_ReadData;
          end else begin
            dm_data_d = bus.Mem_ReadData;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (port_q == PORT_IF) begin
            if_data_d = 32'h0000_0000;
          end else begin
            dm_data_d = 32'h0000_0000;
          end
        end
`endif
        else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      port_q    <= PORT_IF;
      burst_q   <= 4'd0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= 32'h0000_0000;
      rd_q      <= 1'b0;
      wr_q      <= 4'b0000;
      if_data_q <= 32'h0000_0000;
      dm_data_q <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      port_q    <= port_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      if_data_q <= if_data_d;
      dm_data_q <= dm_data_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign bus.Arb_Error = err_q;
`else
  assign bus.Arb_Error = 1'b0;
`endif

  // Memory strobes come straight from the capture registers, gated to BUSY.
  assign bus.Mem_Read      = (state_q == BUSY) & rd_q;
  assign bus.Mem_Write     = (state_q == BUSY) ? wr_q : 4'b0000;
  assign bus.Mem_Address   = (state_q == BUSY) ? addr_q : {ADDR_W{1'b0}};
  assign bus.Mem_WriteData = (state_q == BUSY) ? wdata_q : 32'h0000_0000;
  assign bus.IF_Ready      = (state_q == DONE) & (port_q == PORT_IF);
  assign bus.DM_Ready      = (state_q == DONE) & (port_q == PORT_DM);
  assign bus.IF_Data       = if_data_q;
  assign bus.DM_Data       = dm_data_q;

endmodule
